// File: rtl/rst_seq_gen.sv
// rst_seq_gen: holds all reset domains, then releases them one by one in ascending order.
// Optional RSTSEQ_STAGED_ASSERT_EN: a software request asserts the domains top-down before re-sequencing.
module rst_seq_gen #(
    parameter int unsigned NDOM     = 4,
    parameter int unsigned HOLD_CYC = 16,
    parameter int unsigned GAP_CYC  = 4,
    parameter int unsigned CW       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sw_req,
    output logic            sw_ack,
    output logic [NDOM-1:0] dom_rst_n,
    output logic            busy,
    output logic            done
);

    localparam int unsigned   IW        = (NDOM > 1) ? $clog2(NDOM) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [IW-1:0] IDX_PRE   = IW'((NDOM > 1) ? NDOM - 2 : 0);
`ifdef RSTSEQ_STAGED_ASSERT_EN
    localparam logic [IW-1:0] IDX_TOP   = IW'(NDOM - 1);
`endif

    // Reject parameter sets the counters cannot represent.
    if (NDOM < 1 || HOLD_CYC < 1 || GAP_CYC < 1) begin : g_bad_min
        $error("rst_seq_gen: NDOM, HOLD_CYC and GAP_CYC must all be >= 1");
    end
    if (64'(HOLD_CYC) > (64'd1 << CW) || 64'(GAP_CYC) > (64'd1 << CW)
        || 64'(NDOM) > (64'd1 << CW)) begin : g_bad_cw
        $error("rst_seq_gen: HOLD_CYC, GAP_CYC and NDOM must fit in 2^CW");
    end

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_REL  = 2'd1,
        ST_IDLE = 2'd2
`ifdef RSTSEQ_STAGED_ASSERT_EN
        , ST_ASRT = 2'd3
`endif
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [NDOM-1:0]   dom_rst_n_q;
    logic              busy_q;
    logic              done_q;
    logic              sw_ack_q;

    // One-hot select of the domain following the current index.
    logic [NDOM-1:0]   rel_bit_d;
`ifdef RSTSEQ_STAGED_ASSERT_EN
    logic [NDOM-1:0]   clr_bit_d;
`endif

    always_comb begin
        rel_bit_d = '0;
`ifdef RSTSEQ_STAGED_ASSERT_EN
        clr_bit_d = '0;
`endif
        for (int unsigned k = 0; k < NDOM; k++) begin
            if (k == 32'(idx_q) + 32'd1) begin
                rel_bit_d[k] = 1'b1;
            end
`ifdef RSTSEQ_STAGED_ASSERT_EN
            if (k + 32'd1 == 32'(idx_q)) begin
                clr_bit_d[k] = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        sw_ack_q <= 1'b0;
        if (rst) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            dom_rst_n_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        dom_rst_n_q[0] <= 1'b1;
                        cnt_q          <= '0;
                        idx_q          <= '0;
                        if (NDOM == 1) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_REL;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_REL: begin
                    if (cnt_q == GAP_LAST) begin
                        dom_rst_n_q <= dom_rst_n_q | rel_bit_d;
                        idx_q       <= idx_q + IW'(1);
                        cnt_q       <= '0;
                        // Releasing the last domain completes the sequence.
                        if (idx_q == IDX_PRE) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_IDLE: begin
                    if (sw_req) begin
                        sw_ack_q <= 1'b1;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        cnt_q    <= '0;
`ifdef RSTSEQ_STAGED_ASSERT_EN
                        if (NDOM == 1) begin
                            dom_rst_n_q <= '0;
                            idx_q       <= '0;
                            state_q     <= ST_HOLD;
                        end else begin
                            dom_rst_n_q[NDOM-1] <= 1'b0;
                            idx_q               <= IDX_TOP;
                            state_q             <= ST_ASRT;
                        end
`else
                        dom_rst_n_q <= '0;
                        idx_q       <= '0;
                        state_q     <= ST_HOLD;
`endif
                    end
                end

`ifdef RSTSEQ_STAGED_ASSERT_EN
                // Top-down assertion; reaching domain 0 hands over to the hold phase.
                ST_ASRT: begin
                    if (cnt_q == GAP_LAST) begin
                        dom_rst_n_q <= dom_rst_n_q & ~clr_bit_d;
                        cnt_q       <= '0;
                        if (idx_q == IW'(1)) begin
                            idx_q   <= '0;
                            state_q <= ST_HOLD;
                        end else begin
                            idx_q <= idx_q - IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif

                default: begin
                    state_q     <= ST_HOLD;
                    cnt_q       <= '0;
                    idx_q       <= '0;
                    dom_rst_n_q <= '0;
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign sw_ack    = sw_ack_q;
    assign dom_rst_n = dom_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Reset sequencer that drives the per-domain active-low `rst_n` inputs of downstream register blocks.
- Holds all domains in reset for a fixed time, then releases them one at a time in ascending index order, with a fixed gap between releases.
- Accepts a software reset request through a req/ack handshake and re-runs the sequence.
- Sits at the top of each clock domain, upstream of every block with an `rst_n` input.

Parameters:
- NDOM, 4: number of reset domains (>=1).
- HOLD_CYC, 16: cycles all domains stay asserted before the first release (>=1).
- GAP_CYC, 4: cycles between consecutive domain releases (>=1).
- CW, 8: counter width; HOLD_CYC, GAP_CYC and NDOM must each be <= 2^CW.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- sw_req  in  1  software reset request; level; held by the requester until sw_ack.
- sw_ack  out  1  one-cycle pulse when sw_req is accepted.
- dom_rst_n  out  NDOM  per-domain active-low reset; bit k = domain k.
- busy  out  1  high while a sequence is in progress.
- done  out  1  high from completion of a sequence until the next assertion.

Behaviour:
- Clock and reset: one clock, `clk`; reset is synchronous and active-high, `rst`. Every output is registered.
- States: HOLD, REL, IDLE (plus ASRT when the optional feature is enabled). Internal regs: `cnt` (CW bits), `idx` (domain index).
- rst=1 sampled at an edge, from any state:
  - state=HOLD, cnt=0, idx=0.
  - dom_rst_n=all 0, busy=1, done=0, sw_ack=0.
  - rst has priority over sw_req.
- HOLD, each edge:
  - If cnt==HOLD_CYC-1: dom_rst_n[0]->1, cnt->0, idx->0, state->REL.
  - Otherwise cnt++.
  - With rst deasserted before edge 1, dom_rst_n[0] rises at edge HOLD_CYC.
- REL, each edge:
  - If cnt==GAP_CYC-1: idx++, dom_rst_n[idx+1]->1, cnt->0.
  - Otherwise cnt++.
  - Domain k therefore releases at edge HOLD_CYC + k*GAP_CYC.
- Completion: at the edge that releases domain NDOM-1, state->IDLE, busy->0, done->1, all in the same edge.
  - If NDOM==1, HOLD goes directly to IDLE at edge HOLD_CYC.
- Bits already released stay at 1 until the next reset or software request. No bit is ever re-asserted mid-sequence except by rst.
- IDLE with sw_req=1 at an edge E (software accept):
  - sw_ack=1 for exactly one cycle after E.
  - dom_rst_n->all 0, busy->1, done->0, cnt->0, state->HOLD.
  - Release timing then matches the power-on sequence, offset from E: domain k releases at E + HOLD_CYC + k*GAP_CYC.
- sw_req while busy: ignored, no ack. The request is accepted at the first IDLE edge at which it is still high.
- A request must not be retriggered by a held level: sw_ack is emitted only once per accept; the requester drops sw_req on ack.
- Counter arithmetic: unsigned, CW bits, compared with ==. Wrap-around is unreachable given the parameter constraints.

Optional Feature:
- Macro: RSTSEQ_STAGED_ASSERT_EN.
- Defined: a software accept at edge E enters ASRT instead of HOLD and asserts domains in descending index order.
  - dom_rst_n[NDOM-1] goes to 0 at E.
  - Each next-lower index goes to 0 every GAP_CYC edges.
  - At the edge asserting domain 0: cnt->0, state->HOLD, and normal HOLD/REL follows.
  - busy=1 and done=0 from E.
  - rst always asserts all domains at once and goes straight to HOLD.
- Undefined: ASRT is absent; a software accept asserts all domains at once.

Test Plan (NDOM=4, HOLD_CYC=16, GAP_CYC=4):
- Power-on: rst=1 for 5 cycles, deasserted before edge 1. Required: dom_rst_n=0000 through edge 15; 0001@16, 0011@20, 0111@24, 1111@28; busy 1->0 and done 0->1 @28.
- Soft reset: from IDLE, sw_req=1 accepted at edge E. Required: sw_ack high one cycle only; dom_rst_n=0000@E, 0001@E+16, 1111@E+28; done=0 over E..E+27.
- Request while busy: sw_req raised at edge 10 of the power-on sequence and held. Required: no ack before 28; accept at edge 28 or 29 (first IDLE edge with sw_req high); then full sequence.
- Reset mid-release: rst=1 sampled at edge 22 (dom_rst_n=0011), low from edge 23. Required: 0000@22; 0001 at 22+16=38; 1111@50.
- rst and sw_req both high in IDLE. Required: no sw_ack; behaviour identical to the power-on scenario.
- RSTSEQ_STAGED_ASSERT_EN defined, software accept at E. Required: 0111@E, 0011@E+4, 0001@E+8, 0000@E+12, 0001@E+28, 1111@E+40.
